// File: rtl/burst_param_sequencer.sv
// Steps a burst divider through a small table of {m1, m2, rep} entries, advancing on each
// rising edge of the divider's silent phase so that new parameters land during silence.
module burst_param_sequencer #(
    parameter int unsigned DIV_WIDTH    = 10,
    parameter int unsigned REP_WIDTH    = 4,
    parameter int unsigned PHASE2_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_addr,
    input  logic [DIV_WIDTH-1:0]    cfg_m1,
    input  logic [PHASE2_WIDTH-1:0] cfg_m2,
    input  logic [REP_WIDTH-1:0]    cfg_rep,
    input  logic [1:0]              seq_len,
    input  logic [7:0]              loop_count,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    abort,
    input  logic                    phase_status_in,
    output logic                    enable_out,
    output logic [DIV_WIDTH-1:0]    m1_out,
    output logic [PHASE2_WIDTH-1:0] m2_out,
    output logic [REP_WIDTH-1:0]    rep_out,
    output logic [1:0]              cur_index,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e                  state_q, state_d;
    logic [DIV_WIDTH-1:0]    tbl_m1  [4];
    logic [PHASE2_WIDTH-1:0] tbl_m2  [4];
    logic [REP_WIDTH-1:0]    tbl_rep [4];
    logic [DIV_WIDTH-1:0]    m1_q;
    logic [PHASE2_WIDTH-1:0] m2_q;
    logic [REP_WIDTH-1:0]    rep_q;
    logic [1:0]              idx_q, idx_d;
    logic [7:0]              pass_q, pass_d;
    logic                    stop_q, stop_d;
    logic                    phase_q;
    logic                    done_q, done_d;
    logic                    load;
    logic [1:0]              load_sel;
    logic                    boundary;

    // A zero m1 or m2 means the divider never reaches silence, so the entry is terminal.
    assign boundary = !phase_q && phase_status_in && (m1_q != '0) && (m2_q != '0);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pass_d   = pass_q;
        stop_d   = stop_q;
        done_d   = 1'b0;
        load     = 1'b0;
        load_sel = 2'd0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                if (abort) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    load    = 1'b1;
                    idx_d   = 2'd0;
                    pass_d  = 8'd0;
                    stop_d  = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    if (stop) stop_d = 1'b1;
                    if (boundary) begin
                        if (stop_q) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else if (idx_q < seq_len) begin
                            idx_d    = idx_q + 2'd1;
                            load     = 1'b1;
                            load_sel = idx_q + 2'd1;
                        end else if ((loop_count != 8'd0) && (pass_q == loop_count - 8'd1)) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            idx_d  = 2'd0;
                            pass_d = pass_q + 8'd1;
                            load   = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            m1_q    <= '0;
            m2_q    <= '0;
            rep_q   <= '0;
            idx_q   <= 2'd0;
            pass_q  <= 8'd0;
            stop_q  <= 1'b0;
            phase_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            stop_q  <= stop_d;
            phase_q <= phase_status_in;
            done_q  <= done_d;
            if (load) begin
                m1_q  <= tbl_m1[load_sel];
                m2_q  <= tbl_m2[load_sel];
                rep_q <= tbl_rep[load_sel];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                tbl_m1[i]  <= '0;
                tbl_m2[i]  <= '0;
                tbl_rep[i] <= '0;
            end
        end else if (cfg_we) begin
            tbl_m1[cfg_addr]  <= cfg_m1;
            tbl_m2[cfg_addr]  <= cfg_m2;
            tbl_rep[cfg_addr] <= cfg_rep;
        end
    end

    assign enable_out = (state_q == StRun);
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign cur_index  = idx_q;
    assign m1_out     = m1_q;
    assign m2_out     = m2_q;
    assign rep_out    = rep_q;

endmodule

// File: tb/tb_burst_param_sequencer.sv
// Randomized and directed bench for burst_param_sequencer against a behavioural sequence model.
module tb_burst_param_sequencer;
    localparam int DW = 10;
    localparam int RW = 4;
    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [DW-1:0] cfg_m1;
    logic [PW-1:0] cfg_m2;
    logic [RW-1:0] cfg_rep;
    logic [1:0]    seq_len;
    logic [7:0]    loop_count;
    logic          start, stop, abort, phase_status_in;
    logic          enable_out, busy, done;
    logic [DW-1:0] m1_out;
    logic [PW-1:0] m2_out;
    logic [RW-1:0] rep_out;
    logic [1:0]    cur_index;

    always #5 clk = ~clk;

    burst_param_sequencer #(.DIV_WIDTH(DW), .REP_WIDTH(RW), .PHASE2_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_m1(cfg_m1),
        .cfg_m2(cfg_m2), .cfg_rep(cfg_rep), .seq_len(seq_len), .loop_count(loop_count),
        .start(start), .stop(stop), .abort(abort), .phase_status_in(phase_status_in),
        .enable_out(enable_out), .m1_out(m1_out), .m2_out(m2_out), .rep_out(rep_out),
        .cur_index(cur_index), .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int dut_dones = 0;
    int ph = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the sequence is "waiting", "arming" (one cycle) or "playing".
    bit arming, playing, pend_stop, prev_ph, exp_done;
    int pos, passes, o_m1, o_m2, o_rep;
    int tm1[4], tm2[4], trep[4];

    task automatic model_reset();
        arming = 0; playing = 0; pend_stop = 0; prev_ph = 0; exp_done = 0;
        pos = 0; passes = 0; o_m1 = 0; o_m2 = 0; o_rep = 0;
        for (int i = 0; i < 4; i++) begin tm1[i] = 0; tm2[i] = 0; trep[i] = 0; end
    endtask

    task automatic model_step();
        bit fin = 0;
        int ld = -1;
        exp_done = 0;
        if (arming) begin
            arming = 0;
            if (abort) fin = 1;
            else begin playing = 1; pos = 0; passes = 0; pend_stop = 0; ld = 0; end
        end else if (playing) begin
            if (abort) fin = 1;
            else begin
                if (!prev_ph && phase_status_in && o_m1 != 0 && o_m2 != 0) begin
                    if (pend_stop) fin = 1;
                    else if (pos < int'(seq_len)) begin pos++; ld = pos; end
                    else if (loop_count != 0 && passes == int'(loop_count) - 1) fin = 1;
                    else begin pos = 0; passes = (passes + 1) % 256; ld = 0; end
                end
                if (stop) pend_stop = 1;
            end
        end else if (start) arming = 1;
        if (fin) begin playing = 0; exp_done = 1; end
        if (ld >= 0) begin o_m1 = tm1[ld]; o_m2 = tm2[ld]; o_rep = trep[ld]; end
        if (cfg_we) begin
            tm1[cfg_addr] = int'(cfg_m1); tm2[cfg_addr] = int'(cfg_m2);
            trep[cfg_addr] = int'(cfg_rep);
        end
        prev_ph = phase_status_in;
    endtask

    task automatic compare_all();
        check_eq("enable_out", enable_out, playing);
        check_eq("busy", busy, playing | arming);
        check_eq("done", done, exp_done);
        check_eq("m1_out", m1_out, o_m1);
        check_eq("m2_out", m2_out, o_m2);
        check_eq("rep_out", rep_out, o_rep);
        check_eq("cur_index", cur_index, pos);
        if (done === 1'b1) dut_dones++;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        compare_all();
        start = 0; stop = 0; abort = 0; cfg_we = 0;
    endtask

    task automatic tick_wave(input int per, input int n);
        for (int i = 0; i < n; i++) begin
            phase_status_in = ((ph % per) >= per / 2);
            ph++;
            tick();
        end
    endtask

    task automatic wr(input int a, input int m1, input int m2, input int rep);
        cfg_we = 1; cfg_addr = 2'(a); cfg_m1 = DW'(m1); cfg_m2 = PW'(m2); cfg_rep = RW'(rep);
        tick();
    endtask

    initial begin
        reset = 1; cfg_we = 0; cfg_addr = 0; cfg_m1 = 0; cfg_m2 = 0; cfg_rep = 0;
        seq_len = 0; loop_count = 0; start = 0; stop = 0; abort = 0; phase_status_in = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        reset = 0;

        // Two entries, two passes: e0,e1,e0,e1 then one done.
        wr(0, 4, 20, 2);
        wr(1, 2, 10, 3);
        seq_len = 1; loop_count = 2; ph = 0; dut_dones = 0;
        start = 1;
        tick_wave(8, 60);
        check_eq("pass_limit_done_count", dut_dones, 1);
        check_eq("pass_limit_idle", enable_out, 0);

        // Infinite looping through 300 boundaries: pass counter wraps, never done.
        wr(0, 1, 1, 1);
        seq_len = 0; loop_count = 0; ph = 0; dut_dones = 0;
        start = 1;
        tick_wave(4, 1220);
        check_eq("infinite_no_done", dut_dones, 0);
        check_eq("infinite_enabled", enable_out, 1);
        abort = 1;
        tick_wave(4, 3);

        // Graceful stop inside entry 0 finishes at the next silence rise.
        wr(1, 5, 6, 7); wr(2, 8, 9, 10); wr(3, 11, 12, 13);
        seq_len = 3; ph = 0; dut_dones = 0;
        start = 1;
        tick_wave(16, 4);
        stop = 1;
        tick_wave(16, 20);
        check_eq("stop_done_count", dut_dones, 1);
        check_eq("stop_index", cur_index, 0);

        // Terminal entry (m2=0) held until abort; start+stop in idle still starts.
        wr(0, 3, 0, 1);
        start = 1;
        tick();
        for (int i = 0; i < 50; i++) begin
            phase_status_in = 1'($urandom_range(0, 1));
            tick();
        end
        abort = 1;
        tick();
        check_eq("abort_enable", enable_out, 0);
        check_eq("abort_done", done, 1);
        tick();
        start = 1; stop = 1;
        tick();
        check_eq("start_stop_busy", busy, 1);
        abort = 1;
        tick();

        // Rewrite the active entry mid-run, then reset mid-run.
        wr(0, 4, 20, 2); wr(1, 2, 10, 3);
        seq_len = 1; loop_count = 0; ph = 0;
        start = 1;
        tick_wave(8, 13);
        wr(pos, 33, 44, 5);
        tick_wave(8, 30);
        #2 reset = 1;
        #1 model_reset();
        check_eq("reset_enable", enable_out, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_m1", m1_out, 0);
        check_eq("reset_busy", busy, 0);
        @(negedge clk);
        compare_all();
        reset = 0;

        // Random traffic, including table writes and seq_len changes while running.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 29) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            abort = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 9) == 0) begin
                cfg_we = 1; cfg_addr = 2'($urandom_range(0, 3));
                cfg_m1 = DW'($urandom_range(0, 3)); cfg_m2 = PW'($urandom_range(0, 3));
                cfg_rep = RW'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 49) == 0) seq_len = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) loop_count = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) phase_status_in = ~phase_status_in;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
